uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in baud.
REQ-003 Parameter FIFO_DEPTH, default 4, input byte buffer depth; power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_in  input  8  byte to transmit.
REQ-007 data_in_valid  input  1  data_in holds a byte offered for transmission.
REQ-008 data_in_ready  output  1  block can accept a byte this cycle.
REQ-009 serial_out  output  1  UART line, 8N1 framing, idle high.
REQ-010 tx_busy  output  1  a frame is in progress or the buffer holds bytes.

Function
REQ-011 SYMBOL_EDGE_TIME SHALL equal CLOCK_FREQ/BAUD_RATE with integer division (1085 at defaults); each serial bit lasts exactly SYMBOL_EDGE_TIME cycles.
REQ-012 The bit counter SHALL be clog2(SYMBOL_EDGE_TIME) bits wide, count 0..SYMBOL_EDGE_TIME-1 and wrap to 0 at each bit boundary.
REQ-013 A byte SHALL be accepted on each rising edge where data_in_valid && data_in_ready; data_in is ignored otherwise.
REQ-014 data_in_ready SHALL be 1 exactly when the FIFO is not full; it does not depend on data_in_valid in the same cycle.
REQ-015 Accepted bytes SHALL be transmitted in acceptance order with none lost or duplicated.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-017 IDLE: serial_out=1; if the FIFO is non-empty, pop one byte into the shift register, clear the counters and go to START.
REQ-018 START: serial_out=0 for one bit time, then go to DATA.
REQ-019 DATA: drive the 8 data bits LSB first, one bit time each; after bit 7 go to STOP.
REQ-020 STOP: serial_out=1 for one bit time; at its end, pop and go directly to START if the FIFO is non-empty, else go to IDLE.
REQ-021 Back-to-back frames SHALL have no idle gap: each frame is exactly 10*SYMBOL_EDGE_TIME cycles.
REQ-022 serial_out SHALL be driven from a register.
REQ-023 Latency: with the FSM in IDLE and the FIFO empty, a byte accepted at edge E SHALL drive serial_out low from edge E+1.
REQ-024 A push and a pop on the same edge SHALL leave the FIFO occupancy unchanged and preserve order.
REQ-025 When the FIFO is full, data_in_ready=0 and the offered byte is not taken; it is accepted on the first edge after a pop frees a slot.
REQ-026 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an occupancy count or an extra pointer bit.
REQ-027 tx_busy SHALL be 1 when the state is not IDLE or the FIFO is non-empty.
REQ-028 Changes on data_in while data_in_valid && !data_in_ready SHALL have no effect.

Reset
REQ-029 While reset=1 at a rising edge: state becomes IDLE, FIFO is emptied, counters clear, serial_out=1, data_in_ready=1, tx_busy=0.
REQ-030 Reset during a frame SHALL abandon that frame; serial_out is high from the reset edge, and no remaining bits or buffered bytes are sent.
REQ-031 No byte SHALL be accepted on an edge where reset=1.

Structure
REQ-032 FSM state encodings and the SYMBOL_EDGE_TIME calculation SHALL live in the shared uart_pkg, for reuse by the receiver.
REQ-033 The byte buffer SHALL be the sub-module uart_tx_fifo, parameterized by width 8 and FIFO_DEPTH; the FSM, counters and shift register stay in uart_transmitter.

Verification
REQ-034 Single byte: send 0xA5 after idle -> serial_out low from edge E+1; line then reads 0,1,0,1,0,0,1,0,1,1, each bit held for 1085 cycles; tx_busy returns to 0.
REQ-035 Burst: send 0x00, 0xFF, 0x55, 0x3C continuously -> four frames of 10850 cycles each, no gaps, correct order.
REQ-036 Backpressure: hold data_in_valid=1 with 6 bytes while the line is busy -> data_in_ready drops after 4 are buffered and reasserts one cycle after each pop; all 6 bytes are sent in order.
REQ-037 Reset mid-frame: assert reset during bit 3 of 0x81 with 2 bytes queued -> serial_out=1 from the reset edge, nothing further sent, data_in_ready=1, tx_busy=0.
REQ-038 Simultaneous push and pop: with the FIFO holding 1 byte, push on the same edge as the STOP-to-START pop -> occupancy stays 1 and the next frame carries the older byte.
REQ-039 Loopback: connect serial_out to the team uart receiver and send 256 random bytes at default parameters -> receiver outputs an identical sequence.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM state encoding and bit-timing helpers,
// common to the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Clock cycles per serial bit; integer division truncates any fractional remainder.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Counter width for 0..n-1, kept at least 1 bit so a one-cycle bit time still elaborates.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte buffer for the UART transmitter: the head entry is always
// visible on o_rd_data, and a pop simply advances the read pointer.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; the count tells full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: buffered byte input, framing FSM with a per-bit cycle
// counter, and a registered serial line that idles high.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       tx_busy
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W            = cnt_width(SYMBOL_EDGE_TIME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  uart_state_t      r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_serial;

  logic       w_full;
  logic       w_empty;
  logic       w_bit_end;
  logic       w_pop;
  logic [7:0] w_fifo_data;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (data_in_valid),
    .i_wr_data (data_in),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_bit_end = (r_bit_cnt == CNT_LAST);
  // A byte leaves the buffer either from idle or exactly at the end of a stop bit.
  assign w_pop     = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  assign data_in_ready = !w_full;
  assign serial_out    = r_serial;
  assign tx_busy       = (r_state != ST_IDLE) || !w_empty;

  // The line level for the next bit is loaded on the same edge that changes state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_serial  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_serial <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_fifo_data;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_serial  <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_serial  <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_serial <= 1'b1;
              r_state  <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_serial  <= r_shift[1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (w_pop) begin
              r_shift   <= w_fifo_data;
              r_bit_idx <= '0;
              r_serial  <= 1'b0;
              r_state   <= ST_START;
            end else begin
              r_serial <= 1'b1;
              r_state  <= ST_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_serial <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
